// File: rtl/shift_pkg.sv
// Shared encodings for the multi-cycle shift/rotate unit.
package shift_pkg;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROR = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/shift_step.sv
// Combinational single-step shifter: moves value by k bits (0..STEP) per op.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1,
  parameter int K_W   = 6
) (
  input  logic [WIDTH-1:0] value,
  input  op_t              op,
  input  logic [K_W-1:0]   k,
  output logic [WIDTH-1:0] shifted
);

  // Unrolled chain of 1-bit stages; stage i is applied only when i < k.
  always_comb begin
    shifted = value;
    for (int i = 0; i < STEP; i++) begin
      if (i < int'(k)) begin
        case (op)
          OP_SLL:  shifted = {shifted[WIDTH-2:0], 1'b0};
          OP_SRL:  shifted = {1'b0, shifted[WIDTH-1:1]};
          OP_SRA:  shifted = {shifted[WIDTH-1], shifted[WIDTH-1:1]};
          default: shifted = {shifted[0], shifted[WIDTH-1:1]};
        endcase
      end
    end
  end

endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle shift/rotate unit: shifts STEP bits per clock under a start/done
// handshake, holding the final value in the result register until the next start.
module seq_shifter
  import shift_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5,
  parameter int STEP    = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result
);

  // One extra bit so that STEP == WIDTH is representable.
  localparam int K_W = SHAMT_W + 1;
  localparam logic [K_W-1:0] STEP_K = K_W'(STEP);

  state_t             state_q, state_d;
  op_t                op_q, op_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [SHAMT_W-1:0] rem_q, rem_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [K_W-1:0]     rem_ext;
  logic [K_W-1:0]     k;
  logic [WIDTH-1:0]   stepped;

  assign rem_ext = {1'b0, rem_q};
  assign k       = (rem_ext < STEP_K) ? rem_ext : STEP_K;

  shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP),
    .K_W   (K_W)
  ) u_step (
    .value   (result_q),
    .op      (op_q),
    .k       (k),
    .shifted (stepped)
  );

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    result_d = result_q;
    rem_d    = rem_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          result_d = data_in;
          rem_d    = shamt;
          op_d     = op_t'(op);
          state_d  = (shamt != '0) ? ST_SHIFT : ST_DONE;
        end else if (state_q == ST_DONE) begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        // k never exceeds rem, so the low bits carry the whole amount.
        result_d = stepped;
        rem_d    = rem_q - k[SHAMT_W-1:0];
        state_d  = (rem_d == '0) ? ST_DONE : ST_SHIFT;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_SHIFT);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_SLL;
      result_q <= '0;
      rem_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      result_q <= result_d;
      rem_q    <= rem_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_seq_shifter.sv
// Self-checking bench for seq_shifter: STEP=1 and STEP=4 instances, scoreboard queues.
module tb_seq_shifter;

  logic        clk;
  logic        rst_n;
  logic        start1, start4;
  logic [1:0]  op;
  logic [31:0] data_in;
  logic [4:0]  shamt;
  logic        busy1, done1, busy4, done4;
  logic [31:0] res1, res4;

  int checks = 0;
  int errors = 0;

  logic [31:0] q1[$];
  logic [31:0] q4[$];

  seq_shifter #(.WIDTH(32), .SHAMT_W(5), .STEP(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .op(op), .data_in(data_in),
    .shamt(shamt), .busy(busy1), .done(done1), .result(res1)
  );

  seq_shifter #(.WIDTH(32), .SHAMT_W(5), .STEP(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .op(op), .data_in(data_in),
    .shamt(shamt), .busy(busy4), .done(done4), .result(res4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] ref_op(input logic [1:0] o, input logic [31:0] d,
                                         input logic [4:0] s);
    case (o)
      2'b00:   ref_op = d << s;
      2'b01:   ref_op = d >> s;
      2'b10:   ref_op = 32'($signed(d) >>> s);
      default: ref_op = (d >> s) | (d << (6'd32 - {1'b0, s}));
    endcase
  endfunction

  function automatic logic [31:0] pop_exp(input bit sel4);
    if (sel4) pop_exp = (q4.size() > 0) ? q4.pop_front() : 32'hxxxx_xxxx;
    else      pop_exp = (q1.size() > 0) ? q1.pop_front() : 32'hxxxx_xxxx;
  endfunction

  // Drive one accept from a time away from the clock edge; start drops after the edge.
  task automatic drive_start(input bit sel4, input logic [1:0] o, input logic [31:0] d,
                             input logic [4:0] s);
    op = o; data_in = d; shamt = s;
    if (sel4) begin start4 = 1'b1; q4.push_back(ref_op(o, d, s)); end
    else      begin start1 = 1'b1; q1.push_back(ref_op(o, d, s)); end
    @(posedge clk); #1;
    start1 = 1'b0; start4 = 1'b0;
    data_in = $urandom; shamt = 5'($urandom); op = 2'($urandom);
  endtask

  task automatic wait_done(input bit sel4, output logic [31:0] res, output int busy_cnt,
                           output int cyc, output bit timeout);
    busy_cnt = 0; cyc = 0; timeout = 1'b1; res = 'x;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      cyc++;
      if (sel4 ? busy4 : busy1) busy_cnt++;
      if (sel4 ? done4 : done1) begin
        res = sel4 ? res4 : res1;
        timeout = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start1 = 1'b0; start4 = 1'b0;
    op = 2'b00; data_in = 32'h0; shamt = 5'd0;
    repeat (3) @(negedge clk);
    checks++;
    if ({res1, busy1, done1} !== 34'h0) begin
      errors++;
      $display("FAIL reset_step1: got res=%h busy=%b done=%b want 0/0/0", res1, busy1, done1);
    end
    checks++;
    if ({res4, busy4, done4} !== 34'h0) begin
      errors++;
      $display("FAIL reset_step4: got res=%h busy=%b done=%b want 0/0/0", res4, busy4, done4);
    end
    rst_n = 1'b1;
    @(negedge clk);
    $display("reset released");
  endtask

  task automatic test_sll;
    logic [31:0] r, e; int b, c; bit to;
    drive_start(1'b0, 2'b00, 32'h80020001, 5'd1);
    wait_done(1'b0, r, b, c, to);
    e = pop_exp(1'b0);
    $display("SLL 80020001 by 1: result=%h busy=%0d cycles=%0d", r, b, c);
    checks++;
    if (to || r !== e) begin errors++; $display("FAIL sll_result: got %h want %h (timeout=%0d)", r, e, to); end
    checks++;
    if (b != 1) begin errors++; $display("FAIL sll_busy: got %0d busy cycles want 1", b); end
    checks++;
    if (c != 2) begin errors++; $display("FAIL sll_latency: got done at edge %0d want 2", c); end
  endtask

  task automatic test_ops;
    logic [1:0] ops[3] = '{2'b01, 2'b10, 2'b11};
    logic [4:0] shs[3] = '{5'd1, 5'd1, 5'd4};
    logic [31:0] r, e; int b, c; bit to;
    for (int i = 0; i < 3; i++) begin
      drive_start(1'b0, ops[i], 32'h80020001, shs[i]);
      wait_done(1'b0, r, b, c, to);
      e = pop_exp(1'b0);
      $display("op=%0d shamt=%0d on 80020001: result=%h busy=%0d", ops[i], shs[i], r, b);
      checks++;
      if (to || r !== e) begin errors++; $display("FAIL ops_result op=%0d: got %h want %h", ops[i], r, e); end
      checks++;
      if (b != int'(shs[i])) begin errors++; $display("FAIL ops_busy op=%0d: got %0d want %0d", ops[i], b, shs[i]); end
    end
  endtask

  task automatic test_extremes;
    logic [1:0] ops[3] = '{2'b10, 2'b00, 2'b01};
    logic [4:0] shs[3] = '{5'd31, 5'd31, 5'd0};
    logic [31:0] r, e; int b, c; bit to;
    for (int i = 0; i < 3; i++) begin
      drive_start(1'b0, ops[i], 32'h80020001, shs[i]);
      wait_done(1'b0, r, b, c, to);
      e = pop_exp(1'b0);
      $display("extreme op=%0d shamt=%0d: result=%h busy=%0d cycles=%0d", ops[i], shs[i], r, b, c);
      checks++;
      if (to || r !== e) begin errors++; $display("FAIL extreme_result op=%0d sh=%0d: got %h want %h", ops[i], shs[i], r, e); end
      checks++;
      if (b != int'(shs[i]) || c != int'(shs[i]) + 1) begin
        errors++;
        $display("FAIL extreme_latency sh=%0d: got busy=%0d done_edge=%0d want %0d/%0d", shs[i], b, c, shs[i], shs[i] + 1);
      end
    end
  endtask

  task automatic test_ignore_start;
    logic [31:0] r, e; int b, c, bad; bit to;
    drive_start(1'b0, 2'b01, 32'hDEADBEEF, 5'd8);
    @(negedge clk); @(negedge clk);
    start1 = 1'b1; op = 2'b00; data_in = 32'h12345678; shamt = 5'd3;
    @(negedge clk);
    start1 = 1'b0;
    wait_done(1'b0, r, b, c, to);
    e = pop_exp(1'b0);
    $display("start mid-shift ignored: result=%h", r);
    checks++;
    if (to || r !== e) begin errors++; $display("FAIL ignore_result: got %h want %h", r, e); end
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done1 !== 1'b0 || busy1 !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL ignore_no_extra: got %0d busy/done cycles after completion want 0", bad); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] r, e; int b, c; bit to;
    start1 = 1'b1; op = 2'b00; data_in = 32'h0000F00F; shamt = 5'd2;
    q1.push_back(ref_op(2'b00, 32'h0000F00F, 5'd2));
    @(posedge clk); #1;
    op = 2'b11; data_in = 32'h12345678; shamt = 5'd3;
    q1.push_back(ref_op(2'b11, 32'h12345678, 5'd3));
    wait_done(1'b0, r, b, c, to);
    e = pop_exp(1'b0);
    $display("back-to-back first: result=%h", r);
    checks++;
    if (to || r !== e) begin errors++; $display("FAIL b2b_first: got %h want %h", r, e); end
    @(posedge clk); #1;
    start1 = 1'b0;
    @(negedge clk);
    checks++;
    if (busy1 !== 1'b1) begin errors++; $display("FAIL b2b_no_idle: got busy=%b want 1", busy1); end
    wait_done(1'b0, r, b, c, to);
    e = pop_exp(1'b0);
    $display("back-to-back second: result=%h busy_remaining=%0d", r, b);
    checks++;
    if (to || r !== e) begin errors++; $display("FAIL b2b_second: got %h want %h", r, e); end
    checks++;
    if (b != 2) begin errors++; $display("FAIL b2b_busy: got %0d remaining busy cycles want 2", b); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] r, e; int b, c, bad; bit to;
    drive_start(1'b0, 2'b01, 32'hFFFF0000, 5'd10);
    void'(q1.pop_back());
    @(negedge clk); @(negedge clk); @(negedge clk);
    rst_n = 1'b0;
    #1;
    $display("reset mid-shift: result=%h busy=%b done=%b", res1, busy1, done1);
    checks++;
    if (res1 !== 32'h0) begin errors++; $display("FAIL midrst_result: got %h want 00000000", res1); end
    checks++;
    if (busy1 !== 1'b0 || done1 !== 1'b0) begin errors++; $display("FAIL midrst_flags: got busy=%b done=%b want 0/0", busy1, done1); end
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done1 !== 1'b0 || busy1 !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL midrst_no_done: got %0d busy/done cycles want 0", bad); end
    drive_start(1'b0, 2'b01, 32'h80020001, 5'd2);
    wait_done(1'b0, r, b, c, to);
    e = pop_exp(1'b0);
    $display("SRL 80020001 by 2 after reset: result=%h", r);
    checks++;
    if (to || r !== e) begin errors++; $display("FAIL midrst_after: got %h want %h", r, e); end
  endtask

  task automatic test_step4;
    logic [31:0] r, e, d; logic [1:0] o; logic [4:0] s; int b, c; bit to;
    drive_start(1'b1, 2'b11, 32'h80020001, 5'd7);
    wait_done(1'b1, r, b, c, to);
    e = pop_exp(1'b1);
    $display("STEP4 ROR 80020001 by 7: result=%h busy=%0d", r, b);
    checks++;
    if (to || r !== e) begin errors++; $display("FAIL step4_ror: got %h want %h", r, e); end
    checks++;
    if (b != 2) begin errors++; $display("FAIL step4_busy: got %0d want 2", b); end
    for (int i = 0; i < 24; i++) begin
      o = 2'($urandom_range(0, 3));
      d = $urandom;
      s = 5'($urandom_range(0, 31));
      drive_start(1'b1, o, d, s);
      wait_done(1'b1, r, b, c, to);
      e = pop_exp(1'b1);
      $display("STEP4 op=%0d data=%h shamt=%0d: result=%h busy=%0d", o, d, s, r, b);
      checks++;
      if (to || r !== e) begin errors++; $display("FAIL step4_rand op=%0d sh=%0d: got %h want %h", o, s, r, e); end
      checks++;
      if (b != (int'(s) + 3) / 4 || c != (int'(s) + 3) / 4 + 1) begin
        errors++;
        $display("FAIL step4_latency sh=%0d: got busy=%0d done_edge=%0d want %0d/%0d",
                 s, b, c, (int'(s) + 3) / 4, (int'(s) + 3) / 4 + 1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sll();
    test_ops();
    test_extremes();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_step4();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
